// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencing controller: walks each instruction through
// fetch/decode/exec/mem/wb, handshakes with both memories and drives datapath strobes.
module multicycle_ctrl (
  input  logic        Clk_CPU,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        br_taken,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic [1:0]  npc_sel,
  output logic        RegWrite,
  output logic [1:0]  WDSel,
  output logic [5:0]  EXTOp,
  output logic        illegal,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StTrap
  } state_e;

  typedef enum logic [3:0] {
    ClsNone,
    ClsR,
    ClsIAlu,
    ClsLoad,
    ClsStore,
    ClsBranch,
    ClsLui,
    ClsAuipc,
    ClsJal,
    ClsJalr
  } cls_e;

  localparam logic [5:0] ExtNone  = 6'b000000;
  localparam logic [5:0] ExtShamt = 6'b000001;
  localparam logic [5:0] ExtI     = 6'b000010;
  localparam logic [5:0] ExtS     = 6'b000011;
  localparam logic [5:0] ExtB     = 6'b000100;
  localparam logic [5:0] ExtU     = 6'b000101;
  localparam logic [5:0] ExtJ     = 6'b000110;

  localparam logic [1:0] NpcSeq  = 2'b00;
  localparam logic [1:0] NpcRel  = 2'b01;
  localparam logic [1:0] NpcJalr = 2'b10;

  localparam logic [1:0] WdAlu = 2'b00;
  localparam logic [1:0] WdMem = 2'b01;
  localparam logic [1:0] WdPc4 = 2'b10;

  state_e      state_q;
  cls_e        cls_q;
  logic [5:0]  extop_q;
  logic        illegal_q;
  logic [31:0] retired_q;

  cls_e        dec_cls;
  logic [5:0]  dec_ext;
  logic        dec_ok;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        unused_instr;

  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign unused_instr = ^{instr[31:15], instr[11:7]};

  // Opcode classification; only consulted while in decode.
  always_comb begin
    dec_cls = ClsNone;
    dec_ext = ExtNone;
    dec_ok  = 1'b1;
    case (opcode)
      7'b0110011: begin
        dec_cls = ClsR;
        dec_ext = ExtNone;
      end
      7'b0010011: begin
        dec_cls = ClsIAlu;
        dec_ext = (funct3 == 3'b001 || funct3 == 3'b101) ? ExtShamt : ExtI;
      end
      7'b0000011: begin
        dec_cls = ClsLoad;
        dec_ext = ExtI;
      end
      7'b1100111: begin
        dec_cls = ClsJalr;
        dec_ext = ExtI;
      end
      7'b0100011: begin
        dec_cls = ClsStore;
        dec_ext = ExtS;
      end
      7'b1100011: begin
        dec_cls = ClsBranch;
        dec_ext = ExtB;
      end
      7'b0110111: begin
        dec_cls = ClsLui;
        dec_ext = ExtU;
      end
      7'b0010111: begin
        dec_cls = ClsAuipc;
        dec_ext = ExtU;
      end
      7'b1101111: begin
        dec_cls = ClsJal;
        dec_ext = ExtJ;
      end
      default: begin
        dec_cls = ClsNone;
        dec_ext = ExtNone;
        dec_ok  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk_CPU) begin
    if (rst) begin
      state_q   <= StFetch;
      cls_q     <= ClsNone;
      extop_q   <= ExtNone;
      illegal_q <= 1'b0;
      retired_q <= 32'd0;
    end else begin
      if (PCWrite) begin
        retired_q <= retired_q + 32'd1;
      end
      case (state_q)
        StFetch: begin
          if (imem_ready) begin
            state_q <= StDecode;
          end
        end
        StDecode: begin
          cls_q   <= dec_cls;
          extop_q <= dec_ext;
          if (dec_ok) begin
            state_q <= StExec;
          end else begin
            state_q   <= StTrap;
            illegal_q <= 1'b1;
          end
        end
        StExec: begin
          if (cls_q == ClsBranch) begin
            state_q <= StFetch;
          end else if (cls_q == ClsLoad || cls_q == ClsStore) begin
            state_q <= StMem;
          end else begin
            state_q <= StWb;
          end
        end
        StMem: begin
          if (dmem_ready) begin
            state_q <= (cls_q == ClsStore) ? StFetch : StWb;
          end
        end
        StWb: begin
          state_q <= StFetch;
        end
        StTrap: begin
          state_q <= StTrap;
        end
        default: begin
          state_q <= StFetch;
        end
      endcase
    end
  end

  // Strobes follow state/class; ready and br_taken gate only the documented cases.
  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    npc_sel  = NpcSeq;
    RegWrite = 1'b0;
    WDSel    = WdAlu;
    if (!rst) begin
      case (state_q)
        StFetch: begin
          imem_req = 1'b1;
          IRWrite  = imem_ready;
        end
        StExec: begin
          if (cls_q == ClsBranch) begin
            PCWrite = 1'b1;
            npc_sel = br_taken ? NpcRel : NpcSeq;
          end
        end
        StMem: begin
          dmem_req = 1'b1;
          dmem_we  = (cls_q == ClsStore);
          if (cls_q == ClsStore && dmem_ready) begin
            PCWrite = 1'b1;
            npc_sel = NpcSeq;
          end
        end
        StWb: begin
          RegWrite = 1'b1;
          PCWrite  = 1'b1;
          case (cls_q)
            ClsLoad: begin
              WDSel   = WdMem;
              npc_sel = NpcSeq;
            end
            ClsJal: begin
              WDSel   = WdPc4;
              npc_sel = NpcRel;
            end
            ClsJalr: begin
              WDSel   = WdPc4;
              npc_sel = NpcJalr;
            end
            default: begin
              WDSel   = WdAlu;
              npc_sel = NpcSeq;
            end
          endcase
        end
        default: begin
          imem_req = 1'b0;
        end
      endcase
    end
  end

  assign EXTOp   = extop_q;
  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized scoreboard bench for multicycle_ctrl: stimulus pushes per-instruction
// expectations, a negedge monitor pops and checks them at each PC update.
module tb_multicycle_ctrl;

  logic        Clk_CPU = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        br_taken;
  logic        imem_ready;
  logic        dmem_ready;
  logic        imem_req;
  logic        dmem_req;
  logic        dmem_we;
  logic        IRWrite;
  logic        PCWrite;
  logic [1:0]  npc_sel;
  logic        RegWrite;
  logic [1:0]  WDSel;
  logic [5:0]  EXTOp;
  logic        illegal;
  logic [31:0] retired;

  multicycle_ctrl dut (
    .Clk_CPU   (Clk_CPU),
    .rst       (rst),
    .instr     (instr),
    .br_taken  (br_taken),
    .imem_ready(imem_ready),
    .dmem_ready(dmem_ready),
    .imem_req  (imem_req),
    .dmem_req  (dmem_req),
    .dmem_we   (dmem_we),
    .IRWrite   (IRWrite),
    .PCWrite   (PCWrite),
    .npc_sel   (npc_sel),
    .RegWrite  (RegWrite),
    .WDSel     (WDSel),
    .EXTOp     (EXTOp),
    .illegal   (illegal),
    .retired   (retired)
  );

  always #5 Clk_CPU = ~Clk_CPU;

  typedef struct {
    logic [5:0] ext;
    logic [1:0] npc;
    int         rw;
    logic [1:0] wds;
    int         lat;
    int         ireq;
    int         dreq;
    int         dwe;
    int         ret;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_ret  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: expected behaviour derived from the opcode table and phase latencies.
  function automatic exp_t model(input logic [31:0] ins, input int iw, input int dw,
                                 input bit br, input int ret);
    exp_t       e;
    logic [6:0] op;
    logic [2:0] f3;
    op     = ins[6:0];
    f3     = ins[14:12];
    e.ret  = ret;
    e.ireq = iw + 1;
    e.dreq = 0;
    e.dwe  = 0;
    e.rw   = 1;
    e.wds  = 2'b00;
    e.npc  = 2'b00;
    e.lat  = iw + 4;
    e.ext  = 6'd0;
    case (op)
      7'b0110011: e.ext = 6'd0;
      7'b0010011: e.ext = (f3 == 3'd1 || f3 == 3'd5) ? 6'd1 : 6'd2;
      7'b0000011: begin
        e.ext  = 6'd2;
        e.wds  = 2'b01;
        e.dreq = dw + 1;
        e.lat  = iw + dw + 5;
      end
      7'b1100111: begin
        e.ext = 6'd2;
        e.wds = 2'b10;
        e.npc = 2'b10;
      end
      7'b0100011: begin
        e.ext  = 6'd3;
        e.rw   = 0;
        e.dreq = dw + 1;
        e.dwe  = dw + 1;
        e.lat  = iw + dw + 4;
      end
      7'b1100011: begin
        e.ext = 6'd4;
        e.rw  = 0;
        e.npc = br ? 2'b01 : 2'b00;
        e.lat = iw + 3;
      end
      7'b0110111, 7'b0010111: e.ext = 6'd5;
      7'b1101111: begin
        e.ext = 6'd6;
        e.wds = 2'b10;
        e.npc = 2'b01;
      end
      default: e.ext = 6'd0;
    endcase
    return e;
  endfunction

  // Monitor: per-instruction counters, checked against the scoreboard at each PCWrite.
  int         m_cyc, m_ireq, m_dreq, m_dwe, m_rw, m_irw;
  logic [1:0] m_wds;
  logic       prev_req, prev_pcw;

  always @(negedge Clk_CPU) begin
    exp_t e;
    if (rst) begin
      m_cyc = 0; m_ireq = 0; m_dreq = 0; m_dwe = 0; m_rw = 0; m_irw = 0;
      m_wds = 2'b00; prev_req = 1'b0; prev_pcw = 1'b0;
    end else begin
      if (imem_req && !prev_req) begin
        m_cyc = 0; m_ireq = 0; m_dreq = 0; m_dwe = 0; m_rw = 0; m_irw = 0;
      end
      m_cyc++;
      if (imem_req) m_ireq++;
      if (dmem_req) m_dreq++;
      if (dmem_req && dmem_we) m_dwe++;
      if (IRWrite) m_irw++;
      if (RegWrite) begin
        m_rw++;
        m_wds = WDSel;
      end
      if (PCWrite) begin
        chk("pcwrite_back_to_back", prev_pcw, 0);
        chk("illegal_at_retire", illegal, 0);
        if (sb_q.size() == 0) begin
          chk("scoreboard_nonempty", sb_q.size(), 1);
        end else begin
          e = sb_q.pop_front();
          chk("extop", EXTOp, e.ext);
          chk("npc_sel", npc_sel, e.npc);
          chk("latency", m_cyc, e.lat);
          chk("regwrite_count", m_rw, e.rw);
          if (e.rw != 0) chk("wdsel", m_wds, e.wds);
          chk("imem_req_cycles", m_ireq, e.ireq);
          chk("irwrite_count", m_irw, 1);
          chk("dmem_req_cycles", m_dreq, e.dreq);
          chk("dmem_we_cycles", m_dwe, e.dwe);
          chk("retired_before", retired, e.ret);
        end
      end
      prev_req = imem_req;
      prev_pcw = PCWrite;
    end
  end

  task automatic step();
    @(posedge Clk_CPU);
    #1;
  endtask

  task automatic wait_req(input string name);
    int k;
    k = 0;
    while (!imem_req && k < 50) begin
      imem_ready = 1'($urandom_range(0, 1));
      dmem_ready = 1'($urandom_range(0, 1));
      step();
      k++;
    end
    if (!imem_req) chk(name, imem_req, 1);
  endtask

  task automatic run(input logic [31:0] ins, input int iw, input int dw, input bit br);
    int         k;
    logic [6:0] op;
    wait_req("fetch_req_timeout");
    instr    = ins;
    br_taken = br;
    sb_q.push_back(model(ins, iw, dw, br, n_ret));
    n_ret++;
    for (int w = 0; w <= iw; w++) begin
      imem_ready = (w == iw);
      dmem_ready = 1'($urandom_range(0, 1));
      step();
    end
    imem_ready = 1'b0;
    op = ins[6:0];
    if (op == 7'b0000011 || op == 7'b0100011) begin
      k = 0;
      while (!dmem_req && k < 20) begin
        dmem_ready = 1'($urandom_range(0, 1));
        imem_ready = 1'($urandom_range(0, 1));
        step();
        k++;
      end
      if (!dmem_req) chk("dmem_req_timeout", dmem_req, 1);
      for (int w = 0; w <= dw; w++) begin
        dmem_ready = (w == dw);
        imem_ready = 1'($urandom_range(0, 1));
        step();
      end
      dmem_ready = 1'b0;
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    while (sb_q.size() != 0 && k < 100) begin
      step();
      k++;
    end
    chk("scoreboard_drained", sb_q.size(), 0);
  endtask

  logic [6:0] ops [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
                           7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b0010011};

  initial begin
    logic [31:0] ins;
    rst        = 1'b1;
    instr      = 32'd0;
    br_taken   = 1'b0;
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    repeat (2) step();
    chk("reset_imem_req", imem_req, 0);
    chk("reset_pcwrite", PCWrite, 0);
    chk("reset_regwrite", RegWrite, 0);
    chk("reset_retired", retired, 0);
    chk("reset_illegal", illegal, 0);
    chk("reset_extop", EXTOp, 0);
    rst = 1'b0;
    #1;
    chk("first_fetch_req", imem_req, 1);

    run(32'h00500093, 0, 0, 1'b0);  // ADDI
    run(32'h00209093, 0, 0, 1'b0);  // SLLI
    run(32'h123450B7, 0, 0, 1'b0);  // LUI
    run(32'h0000A083, 0, 3, 1'b0);  // LW, 3 wait states
    run(32'h0020A023, 0, 0, 1'b0);  // SW
    run(32'h00208463, 0, 0, 1'b1);  // BEQ taken
    run(32'h00208463, 0, 0, 1'b0);  // BEQ not taken
    run(32'h008000EF, 0, 0, 1'b0);  // JAL
    run(32'h000080E7, 1, 0, 1'b0);  // JALR
    for (int i = 0; i < 300; i++) begin
      ins      = $urandom;
      ins[6:0] = ops[$urandom_range(0, 9)];
      run(ins, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)));
    end
    drain();

    // Reset in the middle of a load's memory wait.
    wait_req("mid_mem_fetch_timeout");
    instr      = 32'h0000A083;
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    repeat (4) step();
    chk("mem_wait_req_held", dmem_req, 1);
    rst        = 1'b1;
    dmem_ready = 1'b1;
    #1;
    chk("rst_cycle_pcwrite", PCWrite, 0);
    chk("rst_cycle_regwrite", RegWrite, 0);
    chk("rst_cycle_dmem_req", dmem_req, 0);
    step();
    chk("mid_mem_rst_retired", retired, 0);
    rst        = 1'b0;
    dmem_ready = 1'b0;
    n_ret      = 0;
    #1;
    chk("mid_mem_rst_fetch", imem_req, 1);
    run(32'h00500093, 0, 0, 1'b0);
    drain();

    // Illegal opcode traps until reset.
    wait_req("trap_fetch_timeout");
    instr      = 32'h0000007F;
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    step();
    chk("trap_illegal", illegal, 1);
    chk("trap_extop", EXTOp, 0);
    for (int i = 0; i < 10; i++) begin
      imem_ready = 1'($urandom_range(0, 1));
      dmem_ready = 1'($urandom_range(0, 1));
      #1;
      chk("trap_quiet", {imem_req, dmem_req, IRWrite, PCWrite, RegWrite}, 0);
      step();
    end
    chk("trap_sticky", illegal, 1);
    rst = 1'b1;
    step();
    chk("trap_rst_illegal", illegal, 0);
    chk("trap_rst_retired", retired, 0);
    rst   = 1'b0;
    n_ret = 0;
    #1;
    chk("trap_rst_fetch", imem_req, 1);
    run(32'h0020A023, 2, 1, 1'b0);
    run(32'h00500093, 0, 0, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
